// File: rtl/hyperram_responder.sv
// hyperram_responder: single-clock SDR model of a HyperRAM device.
// Decodes the 48-bit command/address, applies the initial latency, and serves
// memory and register (ID0/ID1/CR0/CR1) reads and writes, one 16-bit word per
// enabled clk. LATENCY must be at least 2.
// Optional build macro HYPERRAM_RESP_ERR_EN adds a sticky err output for
// truncated CA phases, out-of-range memory addresses and ID register writes.
module hyperram_responder #(
    parameter int          ADDR_W     = 10,
    parameter int          LATENCY    = 6,
    parameter int          WRAP_WORDS = 16,
    parameter logic [15:0] ID0_VAL    = 16'h0c81,
    parameter logic [15:0] ID1_VAL    = 16'h0001,
    parameter logic [15:0] CR0_RST    = 16'h8f1f,
    parameter logic [15:0] CR1_RST    = 16'hffc1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csn,
    input  logic        ck_en,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    input  logic        rwds_in,
    output logic        rwds_out,
    output logic        rwds_oe
`ifdef HYPERRAM_RESP_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int         WRAP_B     = $clog2(WRAP_WORDS);
    localparam logic [7:0] LAT_SINGLE = 8'(LATENCY);
    localparam logic [7:0] LAT_DOUBLE = 8'(2 * LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_RD,
        S_WR,
        S_REGWR
    } state_t;

    state_t      state_reg;
    logic [1:0]  ca_cnt_reg;
    logic [31:0] ca_hi_reg;        // CA[47:16], first two CA words
    logic [7:0]  lat_cnt_reg;
    logic [31:0] addr_reg;         // full word address of the current beat
    logic        rd_reg;
    logic        space_reg;
    logic        linear_reg;
    logic        regwr_done_reg;
    logic [15:0] cr0_reg;
    logic [15:0] cr1_reg;

    logic [15:0] mem [0:(1 << ADDR_W) - 1];

    logic [31:0] ca_addr;
    logic [31:0] addr_next;
    logic [15:0] rd_word;
    logic        mem_we;

    // Word address assembled from CA[44:16] and the third word's low bits
    assign ca_addr = {ca_hi_reg[28:0], dq_in[2:0]};

    // Memory writes happen only on enabled WR beats that are not masked
    assign mem_we = (state_reg == S_WR) && !csn && ck_en && !rwds_in;

    // Next burst address: linear wraps the whole array, wrapped stays in its group
    always_comb begin
        addr_next = addr_reg;
        if (linear_reg) begin
            addr_next[ADDR_W-1:0] = addr_reg[ADDR_W-1:0] + ADDR_W'(1);
        end else begin
            addr_next[WRAP_B-1:0] = addr_reg[WRAP_B-1:0] + WRAP_B'(1);
        end
    end

    // Word to present on the next read beat: register file or memory array
    always_comb begin
        rd_word = mem[addr_reg[ADDR_W-1:0]];
        if (space_reg) begin
            case (addr_reg)
                32'h0000_0000: rd_word = ID0_VAL;
                32'h0000_0001: rd_word = ID1_VAL;
                32'h0000_0800: rd_word = cr0_reg;
                32'h0000_0801: rd_word = cr1_reg;
                default:       rd_word = 16'h0000;
            endcase
        end
    end

    // Memory array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_reg[ADDR_W-1:0]] <= dq_in;
        end
    end

    // Bus protocol FSM with registered outputs and configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ca_cnt_reg     <= 2'd0;
            ca_hi_reg      <= 32'd0;
            lat_cnt_reg    <= 8'd0;
            addr_reg       <= 32'd0;
            rd_reg         <= 1'b0;
            space_reg      <= 1'b0;
            linear_reg     <= 1'b0;
            regwr_done_reg <= 1'b0;
            cr0_reg        <= CR0_RST;
            cr1_reg        <= CR1_RST;
            dq_out         <= 16'd0;
            dq_oe          <= 1'b0;
            rwds_out       <= 1'b0;
            rwds_oe        <= 1'b0;
        end else if (csn) begin
            // Deselect ends any transaction; a data beat in this cycle is dropped
            state_reg <= S_IDLE;
            dq_out    <= 16'd0;
            dq_oe     <= 1'b0;
            rwds_out  <= 1'b0;
            rwds_oe   <= 1'b0;
        end else if (ck_en) begin
            case (state_reg)
                S_IDLE: begin
                    ca_hi_reg[31:16] <= dq_in;
                    ca_cnt_reg       <= 2'd1;
                    rwds_oe          <= 1'b1;
                    rwds_out         <= cr0_reg[3];
                    state_reg        <= S_CA;
                end
                S_CA: begin
                    if (ca_cnt_reg == 2'd1) begin
                        ca_hi_reg[15:0] <= dq_in;
                        ca_cnt_reg      <= 2'd2;
                    end else begin
                        rd_reg     <= ca_hi_reg[31];
                        space_reg  <= ca_hi_reg[30];
                        linear_reg <= ca_hi_reg[29];
                        addr_reg   <= ca_addr;
                        rwds_oe    <= 1'b0;
                        rwds_out   <= 1'b0;
                        if (!ca_hi_reg[31] && ca_hi_reg[30]) begin
                            regwr_done_reg <= 1'b0;
                            state_reg      <= S_REGWR;
                        end else begin
                            lat_cnt_reg <= (cr0_reg[3] ? LAT_DOUBLE : LAT_SINGLE) - 8'd1;
                            state_reg   <= S_LAT;
                        end
                    end
                end
                S_LAT: begin
                    if (lat_cnt_reg == 8'd1) begin
                        // Last latency cycle: a read loads its first word now so it
                        // is on the bus in the first data cycle
                        if (rd_reg) begin
                            dq_out    <= rd_word;
                            dq_oe     <= 1'b1;
                            rwds_oe   <= 1'b1;
                            rwds_out  <= 1'b1;
                            state_reg <= S_RD;
                            if (!space_reg) begin
                                addr_reg <= addr_next;
                            end
                        end else begin
                            state_reg <= S_WR;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 8'd1;
                    end
                end
                S_RD: begin
                    dq_out <= rd_word;
                    if (!space_reg) begin
                        addr_reg <= addr_next;
                    end
                end
                S_WR: begin
                    addr_reg <= addr_next;
                end
                S_REGWR: begin
                    if (!regwr_done_reg) begin
                        if (addr_reg == 32'h0000_0800) begin
                            cr0_reg <= dq_in;
                        end else if (addr_reg == 32'h0000_0801) begin
                            cr1_reg <= dq_in;
                        end
                        regwr_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef HYPERRAM_RESP_ERR_EN
    logic ca3_fire;
    assign ca3_fire = (state_reg == S_CA) && (ca_cnt_reg == 2'd2) && !csn && ck_en;

    // Sticky protocol error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((csn && state_reg == S_CA) ||
                     (ca3_fire && !ca_hi_reg[30] && (ca_addr[31:ADDR_W] != '0)) ||
                     (ca3_fire && !ca_hi_reg[31] && ca_hi_reg[30] && (ca_addr[31:1] == 31'd0))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hyperram_responder.sv
// Testbench for hyperram_responder: register table, directed latency/burst
// sequences and randomized transactions against a word-level memory model.
module tb_hyperram_responder;

    localparam int LAT  = 6;
    localparam int MEMW = 1024;
    localparam int WRAP = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        csn;
    logic        ck_en;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        rwds_in;
    logic        rwds_out;
    logic        rwds_oe;
`ifdef HYPERRAM_RESP_ERR_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    hyperram_responder dut (
        .clk      (clk),
        .rst      (rst),
        .csn      (csn),
        .ck_en    (ck_en),
        .dq_in    (dq_in),
        .dq_out   (dq_out),
        .dq_oe    (dq_oe),
        .rwds_in  (rwds_in),
        .rwds_out (rwds_out),
        .rwds_oe  (rwds_oe)
`ifdef HYPERRAM_RESP_ERR_EN
        ,
        .err      (err)
`endif
    );

    int tests  = 0;
    int failed = 0;

    logic [15:0] mem_m [MEMW];
    logic [15:0] cr0_m;
    logic [15:0] cr1_m;
    logic [15:0] rbuf  [64];
    logic [15:0] wbuf  [MEMW];
    logic        wmsk  [MEMW];

    typedef struct {
        logic [47:0] ca;
        logic [15:0] exp;
        int          lat;
    } reg_vec_t;

    reg_vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] make_ca(input logic rd, input logic sp, input logic lin,
                                            input logic [31:0] a);
        return {rd, sp, lin, a[31:3], 13'd0, a[2:0]};
    endfunction

    function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
        return {ca[44:16], ca[2:0]};
    endfunction

    // Index of the i-th beat of a memory burst
    function automatic int mem_idx(input logic [47:0] ca, input int i);
        int a;
        a = int'(ca_word_addr(ca) % MEMW);
        if (ca[45]) return (a + i) % MEMW;
        return (a / WRAP) * WRAP + ((a + i) % WRAP);
    endfunction

    function automatic logic [15:0] reg_model(input logic [31:0] a);
        if (a == 32'h0)   return 16'h0c81;
        if (a == 32'h1)   return 16'h0001;
        if (a == 32'h800) return cr0_m;
        if (a == 32'h801) return cr1_m;
        return 16'h0000;
    endfunction

    function automatic int cur_lat();
        return cr0_m[3] ? 2 * LAT : LAT;
    endfunction

    task automatic send_ca(input logic [47:0] ca, input string tag);
        csn   = 1'b0;
        ck_en = 1'b1;
        dq_in = ca[47:32];
        tick();
        chk({tag, "_ca_rwds"}, 32'({rwds_oe, rwds_out}), 32'({1'b1, cr0_m[3]}));
        dq_in = ca[31:16];
        tick();
        dq_in = ca[15:0];
        tick();
    endtask

    task automatic read_burst(input logic [47:0] ca, input int n, input int stall_pct,
                              input int fixed_stall, input string tag, output int lat);
        int exp_lat;
        int cyc;
        int stalls;
        int left;
        exp_lat = cur_lat();
        send_ca(ca, tag);
        cyc    = 1;
        stalls = 0;
        left   = fixed_stall;
        while (!dq_oe && cyc < 400) begin
            if (left > 0 && cyc >= 2) begin
                ck_en = 1'b0;
                left--;
                stalls++;
            end else if (int'($urandom_range(0, 99)) < stall_pct) begin
                ck_en = 1'b0;
                stalls++;
            end else begin
                ck_en = 1'b1;
            end
            dq_in = 16'($urandom);
            tick();
            cyc++;
        end
        ck_en = 1'b1;
        lat   = cyc;
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat + stalls));
        chk({tag, "_drive"}, 32'({dq_oe, rwds_oe, rwds_out}), 32'(3'b111));
        rbuf[0] = dq_out;
        for (int i = 1; i < n; i++) begin
            if (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) begin
                ck_en = 1'b0;
                tick();
                chk({tag, "_hold"}, 32'(dq_out), 32'(rbuf[i-1]));
                ck_en = 1'b1;
            end
            tick();
            rbuf[i] = dq_out;
        end
        csn = 1'b1;
        tick();
        chk({tag, "_release"}, 32'({dq_oe, rwds_oe}), 32'd0);
    endtask

    task automatic write_burst(input logic [47:0] ca, input int n, input int stall_pct,
                               input string tag);
        int en;
        int g;
        send_ca(ca, tag);
        en = 0;
        g  = 0;
        while (en < cur_lat() - 1 && g < 400) begin
            ck_en   = (int'($urandom_range(0, 99)) < stall_pct) ? 1'b0 : 1'b1;
            dq_in   = 16'($urandom);
            rwds_in = 1'($urandom);
            tick();
            if (ck_en) en++;
            g++;
        end
        for (int i = 0; i < n; i++) begin
            if (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) begin
                ck_en   = 1'b0;
                dq_in   = 16'($urandom);
                rwds_in = 1'b0;
                tick();
            end
            ck_en   = 1'b1;
            dq_in   = wbuf[i];
            rwds_in = wmsk[i];
            tick();
            if (!wmsk[i]) mem_m[mem_idx(ca, i)] = wbuf[i];
        end
        chk({tag, "_wr_oe"}, 32'({dq_oe, rwds_oe}), 32'd0);
        csn     = 1'b1;
        ck_en   = 1'b1;
        dq_in   = 16'($urandom);
        rwds_in = 1'b0;
        tick();
    endtask

    task automatic reg_write(input logic [47:0] ca, input logic [15:0] data, input int extra,
                             input string tag);
        logic [31:0] a;
        a = ca_word_addr(ca);
        send_ca(ca, tag);
        ck_en   = 1'b1;
        dq_in   = data;
        rwds_in = 1'b0;
        tick();
        for (int i = 0; i < extra; i++) begin
            dq_in = 16'($urandom);
            tick();
        end
        csn = 1'b1;
        tick();
        if (a == 32'h800) cr0_m = data;
        if (a == 32'h801) cr1_m = data;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [15:0] old_3ff;
        logic [15:0] old_002;
        logic [47:0] ca;
        int op;
        int n;
        logic [31:0] a;

        rst     = 1'b1;
        csn     = 1'b1;
        ck_en   = 1'b1;
        dq_in   = 16'd0;
        rwds_in = 1'b0;
        cr0_m   = 16'h8f1f;
        cr1_m   = 16'hffc1;
        repeat (3) tick();
        chk("reset_outputs", 32'({dq_out, dq_oe, rwds_out, rwds_oe}), 32'd0);
`ifdef HYPERRAM_RESP_ERR_EN
        chk("reset_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Register reads at reset configuration (double latency)
        tbl[0] = '{48'hc000_0000_0000, 16'h0c81, 12};
        tbl[1] = '{48'hc000_0000_0001, 16'h0001, 12};
        tbl[2] = '{48'hc000_0100_0000, 16'h8f1f, 12};
        tbl[3] = '{48'hc000_0100_0001, 16'hffc1, 12};
        tbl[4] = '{48'hc000_0000_0002, 16'h0000, 12};
        tbl[5] = '{48'hc000_0100_0002, 16'h0000, 12};
        for (int k = 0; k < 6; k++) begin
            read_burst(tbl[k].ca, 3, 0, 0, $sformatf("tbl%0d", k), lat);
            chk($sformatf("tbl%0d_latency", k), 32'(lat), 32'(tbl[k].lat));
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("tbl%0d_word%0d", k, i), 32'(rbuf[i]), 32'(tbl[k].exp));
            end
        end

        // CR1 write with trailing words ignored; ID0 write ignored
        reg_write(make_ca(1'b0, 1'b1, 1'b1, 32'h801), 16'h1234, 2, "cr1w");
        reg_write(make_ca(1'b0, 1'b1, 1'b1, 32'h000), 16'hffff, 0, "id0w");
        read_burst(make_ca(1'b1, 1'b1, 1'b1, 32'h801), 2, 0, 0, "cr1r", lat);
        chk("cr1_value", 32'(rbuf[0]), 32'h1234);
        read_burst(make_ca(1'b1, 1'b1, 1'b1, 32'h000), 1, 0, 0, "id0r", lat);
        chk("id0_unchanged", 32'(rbuf[0]), 32'h0c81);

        // CR0 to single latency
        reg_write(48'h6000_0100_0000, 16'h8f17, 0, "cr0w");
        read_burst(48'hc000_0100_0000, 1, 0, 0, "cr0r", lat);
        chk("cr0_value", 32'(rbuf[0]), 32'h8f17);
        chk("cr0_single_lat", 32'(lat), 32'd6);

        // Fill memory with known data
        for (int i = 0; i < MEMW; i++) begin
            wbuf[i] = 16'($urandom);
            wmsk[i] = 1'b0;
        end
        write_burst(make_ca(1'b0, 1'b0, 1'b1, 32'h0), MEMW, 0, "fill");

        // Linear write across the top of the array with a masked second word
        old_3ff = mem_m[10'h3ff];
        old_002 = mem_m[2];
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        wmsk[0] = 1'b0;     wmsk[1] = 1'b1;     wmsk[2] = 1'b0;     wmsk[3] = 1'b0;
        write_burst(make_ca(1'b0, 1'b0, 1'b1, 32'h3fe), 4, 0, "lin4w");
        read_burst(make_ca(1'b1, 1'b0, 1'b1, 32'h3fe), 5, 0, 0, "lin4r", lat);
        chk("lin4_lat", 32'(lat), 32'd6);
        chk("lin4_w0", 32'(rbuf[0]), 32'h1111);
        chk("lin4_w1_masked", 32'(rbuf[1]), 32'(old_3ff));
        chk("lin4_w2", 32'(rbuf[2]), 32'h3333);
        chk("lin4_w3", 32'(rbuf[3]), 32'h4444);
        chk("lin4_after_csn", 32'(rbuf[4]), 32'(old_002));

        // Wrapped read crossing the 16-word group boundary
        read_burst(make_ca(1'b1, 1'b0, 1'b0, 32'h00e), 4, 0, 0, "wrap", lat);
        chk("wrap_w0", 32'(rbuf[0]), 32'(mem_m[14]));
        chk("wrap_w1", 32'(rbuf[1]), 32'(mem_m[15]));
        chk("wrap_w2", 32'(rbuf[2]), 32'(mem_m[0]));
        chk("wrap_w3", 32'(rbuf[3]), 32'(mem_m[1]));

        // Three stalled cycles in latency delay first data by three
        read_burst(make_ca(1'b1, 1'b0, 1'b1, 32'h100), 2, 0, 3, "stall", lat);
        chk("stall_latency", 32'(lat), 32'd9);
        chk("stall_w0", 32'(rbuf[0]), 32'(mem_m[256]));
        chk("stall_w1", 32'(rbuf[1]), 32'(mem_m[257]));

        // Abort after two CA words, then a clean read
        csn   = 1'b0;
        ck_en = 1'b1;
        dq_in = 16'hc000;
        tick();
        dq_in = 16'h0000;
        tick();
        csn = 1'b1;
        tick();
        chk("abort_release", 32'({dq_oe, rwds_oe}), 32'd0);
        read_burst(make_ca(1'b1, 1'b0, 1'b1, 32'h055), 2, 0, 0, "post_abort", lat);
        chk("post_abort_w0", 32'(rbuf[0]), 32'(mem_m[16'h55]));
        chk("post_abort_w1", 32'(rbuf[1]), 32'(mem_m[16'h56]));
`ifdef HYPERRAM_RESP_ERR_EN
        chk("abort_err", 32'(err), 32'd1);
`endif

        // Reset in the middle of a read burst
        send_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h200), "rstburst");
        repeat (LAT + 2) tick();
        chk("rstburst_active", 32'(dq_oe), 32'd1);
        rst = 1'b1;
        tick();
        chk("rstburst_outputs", 32'({dq_out, dq_oe, rwds_out, rwds_oe}), 32'd0);
        rst = 1'b0;
        csn = 1'b1;
        tick();
        cr0_m = 16'h8f1f;
        cr1_m = 16'hffc1;
        read_burst(48'hc000_0100_0000, 1, 0, 0, "cr0_after_rst", lat);
        chk("cr0_rst_value", 32'(rbuf[0]), 32'h8f1f);
        chk("cr0_rst_lat", 32'(lat), 32'd12);
        reg_write(48'h6000_0100_0000, 16'h8f17, 0, "cr0w2");

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 9));
            n  = int'($urandom_range(1, 8));
            a  = 32'($urandom_range(0, MEMW - 1));
            if (op <= 3) begin
                ca = make_ca(1'b0, 1'b0, 1'($urandom), a);
                for (int i = 0; i < n; i++) begin
                    wbuf[i] = 16'($urandom);
                    wmsk[i] = (int'($urandom_range(0, 99)) < 20);
                end
                write_burst(ca, n, 15, "rnd_wr");
            end else if (op <= 7) begin
                ca = make_ca(1'b1, 1'b0, 1'($urandom), a);
                read_burst(ca, n, 15, 0, "rnd_rd", lat);
                for (int i = 0; i < n; i++) begin
                    chk($sformatf("rnd_rd_t%0d_w%0d", t, i), 32'(rbuf[i]),
                        32'(mem_m[mem_idx(ca, i)]));
                end
            end else if (op == 8) begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h800;
                    1:       a = 32'h801;
                    2:       a = 32'h001;
                    default: a = 32'h005;
                endcase
                reg_write(make_ca(1'b0, 1'b1, 1'b1, a), 16'($urandom), 1, "rnd_regw");
            end else begin
                case ($urandom_range(0, 4))
                    0:       a = 32'h000;
                    1:       a = 32'h001;
                    2:       a = 32'h800;
                    3:       a = 32'h801;
                    default: a = 32'h803;
                endcase
                read_burst(make_ca(1'b1, 1'b1, 1'($urandom), a), 2, 15, 0, "rnd_regr", lat);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("rnd_regr_t%0d_w%0d", t, i), 32'(rbuf[i]), 32'(reg_model(a)));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
